// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: defaults, FSM encodings, address check.
package dmem_pkg;

   localparam int unsigned DMEM_DATA_W      = 32;
   localparam int unsigned DMEM_ADDR_W      = 32;
   localparam int unsigned DMEM_DEPTH_LOG2  = 8;
   localparam int unsigned DMEM_WAIT_STATES = 2;
   localparam int unsigned DMEM_CNT_W       = 4;   // holds 0..15 wait states

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // True when the byte address is misaligned or has any bit set above the RAM index.
   function automatic logic dmem_addr_err(input logic [63:0] addr,
                                          input int unsigned addr_w,
                                          input int unsigned depth_log2);
      logic err;
      err = (addr[1:0] != 2'b00);
      for (int unsigned i = 0; i < 64; i++) begin
         if ((i >= depth_log2 + 2) && (i < addr_w) && addr[i]) begin
            err = 1'b1;
         end
      end
      return err;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM-stage initiator and the data-memory responder.
interface dmem_responder_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with one write enable and a registered read port.
module dmem_ram #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);
   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write on enable, read the addressed word every edge (contents are never reset).
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait states, held response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W      = DMEM_DATA_W,
   parameter int unsigned ADDR_W      = DMEM_ADDR_W,
   parameter int unsigned DEPTH_LOG2  = DMEM_DEPTH_LOG2,
   parameter int unsigned WAIT_STATES = DMEM_WAIT_STATES
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus
);
   localparam int unsigned CNT_W = DMEM_CNT_W;
   localparam int unsigned IDX_W = DEPTH_LOG2;

   logic [1:0]        state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic              we_q,        we_d;
   logic [IDX_W-1:0]  idx_q,       idx_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic              err_q,       err_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;

   logic              ram_we_c;
   logic              ram_we_gated_c;
   logic [IDX_W-1:0]  ram_addr_c;
   logic [DATA_W-1:0] ram_rdata_c;

   // In IDLE the RAM reads the incoming address so the word is ready well before RESP entry.
   assign ram_addr_c     = (state_q == ST_IDLE) ? bus.req_addr[DEPTH_LOG2+1:2] : idx_q;
   // Reset wins over the committing edge, so an aborted store never lands.
   assign ram_we_gated_c = ram_we_c & rst;

   dmem_ram #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we_gated_c),
      .addr_i  (ram_addr_c),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata_c)
   );

   // State and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next-state, request capture, access commit and response generation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      ram_we_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               we_d        = bus.req_we;
               idx_d       = bus.req_addr[DEPTH_LOG2+1:2];
               wdata_d     = bus.req_wdata;
               err_d       = dmem_addr_err(64'(bus.req_addr), ADDR_W, DEPTH_LOG2);
               cnt_d       = CNT_W'(WAIT_STATES);
               req_ready_d = 1'b0;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               ram_we_c    = we_q & ~err_q;
               rsp_rdata_d = (we_q | err_q) ? '0 : ram_rdata_c;
               rsp_err_d   = err_q;
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with two wait states, one with none, sharing clock and reset.
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   dmem_responder_if #(.DATA_W(32), .ADDR_W(32)) b0 ();
   dmem_responder_if #(.DATA_W(32), .ADDR_W(32)) b1 ();

   dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_STATES(2)) u_dut0 (
      .clk (clk), .rst (rst), .bus (b0.slave)
   );
   dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut1 (
      .clk (clk), .rst (rst), .bus (b1.slave)
   );

   task automatic drive(input bit sel, input logic v, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (sel) begin
         b1.req_valid = v; b1.req_we = we; b1.req_addr = addr; b1.req_wdata = wdata;
      end else begin
         b0.req_valid = v; b0.req_we = we; b0.req_addr = addr; b0.req_wdata = wdata;
      end
   endtask

   task automatic set_ack(input bit sel, input logic v);
      if (sel) b1.rsp_ready = v; else b0.rsp_ready = v;
   endtask

   // Issue one request from an idle DUT; lat counts edges after the accept edge until rsp_valid.
   task automatic txn(input bit sel, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit ack,
                      output int lat, output logic [31:0] rdata, output logic err);
      logic v;
      drive(sel, 1'b1, we, addr, wdata);
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      lat = 0;
      v   = 1'b0;
      while (!v && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         v = sel ? b1.rsp_valid : b0.rsp_valid;
      end
      rdata = sel ? b1.rsp_rdata : b0.rsp_rdata;
      err   = sel ? b1.rsp_err   : b0.rsp_err;
      if (ack) begin
         set_ack(sel, 1'b1);
         @(posedge clk); #1;
         set_ack(sel, 1'b0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      total++; if (b0.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", b0.req_ready); end
      total++; if (b0.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", b0.rsp_valid); end
      total++; if (b0.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", b0.rsp_rdata); end
      total++; if (b0.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", b0.rsp_err); end
      total++; if (b1.req_ready !== 1'b1 || b1.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_dut1 ready=%b valid=%b want ready=1 valid=0", b1.req_ready, b1.rsp_valid);
      end
   endtask

   task automatic test_preload();
      int lat; logic [31:0] rd; logic er;
      txn(1'b0, 1'b1, 32'h0000_0000, 32'h1111_2222, 1'b1, lat, rd, er);
      total++; if (er !== 1'b0 || lat != 3) begin bad++; $display("FAIL preload0 err=%b lat=%0d want err=0 lat=3", er, lat); end
      txn(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b1, lat, rd, er);
      total++; if (er !== 1'b0) begin bad++; $display("FAIL preload20 err=%b want 0", er); end
   endtask

   task automatic test_store_load();
      int lat; logic [31:0] rd; logic er;
      txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, lat, rd, er);
      total++; if (lat != 3) begin bad++; $display("FAIL store_latency got=%0d want=3", lat); end
      total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL store_rsp err=%b rdata=%h want err=0 rdata=0", er, rd); end
      txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, lat, rd, er);
      total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_raw got=%h want=deadbeef", rd); end
      total++; if (er !== 1'b0 || lat != 3) begin bad++; $display("FAIL load_rsp err=%b lat=%0d want err=0 lat=3", er, lat); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic er;
      txn(1'b0, 1'b0, 32'h0000_0013, 32'h0, 1'b1, lat, rd, er);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL misaligned_load err=%b rdata=%h want err=1 rdata=0", er, rd); end
      total++; if (lat != 3) begin bad++; $display("FAIL err_latency got=%0d want=3", lat); end
      txn(1'b0, 1'b1, 32'h0000_0400, 32'h0000_1234, 1'b1, lat, rd, er);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL range_store err=%b rdata=%h want err=1 rdata=0", er, rd); end
      txn(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, lat, rd, er);
      total++; if (rd !== 32'h1111_2222 || er !== 1'b0) begin bad++; $display("FAIL range_no_write got=%h err=%b want=11112222 err=0", rd, er); end
      // 0x12 aliases word 4 (0x10) if the alignment check were ignored.
      txn(1'b0, 1'b1, 32'h0000_0012, 32'h0000_5555, 1'b1, lat, rd, er);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL misaligned_store err=%b want 1", er); end
      txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, lat, rd, er);
      total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL misaligned_no_write got=%h want=deadbeef", rd); end
      txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b1, lat, rd, er);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL high_bit_range err=%b rdata=%h want err=1 rdata=0", er, rd); end
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] rd; logic er;
      int hold_bad = 0;
      txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, lat, rd, er);
      total++; if (lat != 3 || rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bp_first lat=%0d rdata=%h want lat=3 rdata=deadbeef", lat, rd); end
      // A competing request during the held response must be ignored.
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_0BAD);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (b0.rsp_valid !== 1'b1 || b0.rsp_rdata !== 32'hDEAD_BEEF || b0.req_ready !== 1'b0) hold_bad++;
      end
      total++; if (hold_bad != 0) begin bad++; $display("FAIL bp_hold unstable_cycles=%0d want=0", hold_bad); end
      set_ack(1'b0, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_ack(1'b0, 1'b0);
      total++; if (b0.rsp_valid !== 1'b0 || b0.req_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release valid=%b ready=%b want valid=0 ready=1", b0.rsp_valid, b0.req_ready);
      end
      txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, lat, rd, er);
      total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bp_ignored_store got=%h want=deadbeef", rd); end
   endtask

   task automatic test_reset_mid_wait();
      int lat; logic [31:0] rd; logic er;
      int seen = 0;
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (b0.rsp_valid === 1'b1) seen++;
         @(posedge clk); #1;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL midwait_no_rsp valid_cycles=%0d want=0", seen); end
      txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b1, lat, rd, er);
      total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL midwait_not_committed got=%h err=%b want=0 err=0", rd, er); end
   endtask

   task automatic test_zero_wait();
      int lat; logic [31:0] rd; logic er;
      int acc_edge [$];
      int gap_bad = 0;
      int data_bad = 0;
      logic acc;
      txn(1'b1, 1'b1, 32'h0000_0030, 32'hA0A0_A0A0, 1'b1, lat, rd, er);
      total++; if (lat != 1) begin bad++; $display("FAIL zw_latency got=%0d want=1", lat); end
      txn(1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b1, lat, rd, er);
      total++; if (rd !== 32'hA0A0_A0A0 || lat != 1) begin bad++; $display("FAIL zw_load rdata=%h lat=%0d want=a0a0a0a0 lat=1", rd, lat); end
      // Continuous requests with the response always accepted: accept, respond, return to IDLE.
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
      set_ack(1'b1, 1'b1);
      for (int e = 1; e <= 12; e++) begin
         acc = b1.req_ready;
         @(posedge clk); #1;
         if (acc) acc_edge.push_back(e);
         if (b1.rsp_valid === 1'b1 && b1.rsp_rdata !== 32'hA0A0_A0A0) data_bad++;
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 1; i < acc_edge.size(); i++) begin
         if (acc_edge[i] - acc_edge[i-1] != 3) gap_bad++;
      end
      total++; if (acc_edge.size() != 4) begin bad++; $display("FAIL zw_accept_count got=%0d want=4", acc_edge.size()); end
      total++; if (gap_bad != 0) begin bad++; $display("FAIL zw_accept_spacing bad_gaps=%0d want=0", gap_bad); end
      total++; if (data_bad != 0) begin bad++; $display("FAIL zw_b2b_data bad=%0d want=0", data_bad); end
      repeat (3) @(posedge clk);
      #1 set_ack(1'b1, 1'b0);
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      set_ack(1'b0, 1'b0);
      set_ack(1'b1, 1'b0);
      test_reset();
      test_preload();
      test_store_load();
      test_errors();
      test_backpressure();
      test_reset_mid_wait();
      test_zero_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
